// File: rtl/gbe_rx_pkg.sv
// Shared encodings and sizes for the CPU receive double buffer.
package gbe_rx_pkg;

  localparam logic [1:0] FILL_IDLE      = 2'd0;
  localparam logic [1:0] FILL_FILL      = 2'd1;
  localparam logic [1:0] FILL_DROP      = 2'd2;
  localparam logic [1:0] FILL_WAIT_SWAP = 2'd3;

  localparam logic [1:0] CPU_FREE    = 2'd0;
  localparam logic [1:0] CPU_OFFERED = 2'd1;
  localparam logic [1:0] CPU_OWNED   = 2'd2;

  localparam int MAX_FRAME_BYTES = 2048;
  localparam int CNT_W           = 16;
  localparam int SIZE_W          = 12;

  typedef logic [1:0] fill_state_t;
  typedef logic [1:0] cpu_state_t;

  // Big-endian packing; lane 0 starts a fresh word so unused low bytes stay zero.
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
    logic [31:0] w;
    w = (lane == 2'd0) ? 32'h0 : word;
    case (lane)
      2'd0:    w[31:24] = data;
      2'd1:    w[23:16] = data;
      2'd2:    w[15:8]  = data;
      default: w[7:0]   = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/gbe_rx_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module gbe_rx_dpram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gbe_cpu_rx_buffer.sv
// Double-buffered receive path handing complete frames to the CPU.
//   fill FSM   | meaning
//   IDLE       | waiting for first byte of a frame
//   FILL       | packing bytes into fill bank F
//   DROP       | oversize frame, discarding until eof
//   WAIT_SWAP  | good frame complete in F, waiting for CPU side (arrivals discarded)
//   cpu FSM    | meaning
//   FREE       | CPU bank may be replaced
//   OFFERED    | ready high, waiting for ack
//   OWNED      | CPU reading bank !F, waiting for ack to release
module gbe_cpu_rx_buffer
  import gbe_rx_pkg::*;
#(
  parameter int BANK_AWIDTH = 9
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_eof,
  input  logic                   rx_bad,
  input  logic [BANK_AWIDTH-1:0] cpu_rx_buffer_addr,
  output logic [31:0]            cpu_rx_buffer_rd_data,
  output logic [SIZE_W-1:0]      cpu_rx_size,
  output logic                   cpu_rx_ready,
  input  logic                   cpu_rx_ack,
  output logic [CNT_W-1:0]       rx_frame_count,
  output logic [CNT_W-1:0]       rx_drop_count
);

  localparam logic [SIZE_W-1:0] MAX_BYTES = SIZE_W'(MAX_FRAME_BYTES);

  fill_state_t fill_state;
  cpu_state_t  cpu_state;
  logic        fill_bank;
  logic        busy_disc;
  logic [SIZE_W-1:0] byte_cnt;
  logic [SIZE_W-1:0] fill_size;
  logic [31:0] pk_word;
  logic        wr_en;
  logic [BANK_AWIDTH:0] wr_addr;
  logic [31:0] wr_data;

  logic        swap;
  logic        over;
  logic        take;
  logic        wr_bank;
  logic        drop_evt;
  logic [SIZE_W-1:0] idx;
  logic [31:0] byte_word;

  always_comb begin
    swap = (cpu_state == CPU_FREE) && (fill_state == FILL_WAIT_SWAP) && cpu_rx_ack;
    over = (fill_state == FILL_FILL) && (byte_cnt == MAX_BYTES);
    // A byte landing in the swap cycle starts the next frame in the new fill bank.
    take = rx_valid && !over &&
           ((fill_state == FILL_IDLE) || (fill_state == FILL_FILL) ||
            ((fill_state == FILL_WAIT_SWAP) && swap && !busy_disc));
    idx       = (fill_state == FILL_FILL) ? byte_cnt : '0;
    byte_word = pack_byte(pk_word, idx[1:0], rx_data);
    wr_bank   = (fill_state == FILL_WAIT_SWAP) ? ~fill_bank : fill_bank;
    drop_evt  = rx_valid && rx_eof &&
                ((take && rx_bad) || over || (fill_state == FILL_DROP) ||
                 ((fill_state == FILL_WAIT_SWAP) && !take));
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      fill_state <= FILL_IDLE;
      busy_disc  <= 1'b0;
      byte_cnt   <= '0;
      fill_size  <= '0;
      pk_word    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= take && ((idx[1:0] == 2'd3) || rx_eof);
      if (take) begin
        pk_word <= byte_word;
        wr_data <= byte_word;
        wr_addr <= {wr_bank, idx[BANK_AWIDTH+1:2]};
        if (rx_eof) begin
          fill_size  <= idx;
          fill_state <= rx_bad ? FILL_IDLE : FILL_WAIT_SWAP;
        end else begin
          byte_cnt   <= idx + SIZE_W'(1);
          fill_state <= FILL_FILL;
        end
      end else begin
        case (fill_state)
          FILL_FILL: if (rx_valid) fill_state <= rx_eof ? FILL_IDLE : FILL_DROP;
          FILL_DROP: if (rx_valid && rx_eof) fill_state <= FILL_IDLE;
          FILL_WAIT_SWAP: begin
            if (swap) begin
              busy_disc  <= 1'b0;
              fill_state <= (busy_disc && !(rx_valid && rx_eof)) ? FILL_DROP : FILL_IDLE;
            end else if (rx_valid) begin
              busy_disc <= !rx_eof;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      cpu_state      <= CPU_FREE;
      fill_bank      <= 1'b0;
      cpu_rx_size    <= '0;
      cpu_rx_ready   <= 1'b0;
      rx_frame_count <= '0;
    end else begin
      case (cpu_state)
        CPU_FREE: begin
          if (swap) begin
            fill_bank      <= ~fill_bank;
            cpu_rx_size    <= fill_size;
            cpu_rx_ready   <= 1'b1;
            rx_frame_count <= rx_frame_count + CNT_W'(1);
            cpu_state      <= CPU_OFFERED;
          end
        end
        CPU_OFFERED: begin
          if (cpu_rx_ready && cpu_rx_ack) begin
            cpu_rx_ready <= 1'b0;
            cpu_state    <= CPU_OWNED;
          end
        end
        CPU_OWNED: if (cpu_rx_ack) cpu_state <= CPU_FREE;
        default:   cpu_state <= CPU_FREE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) rx_drop_count <= '0;
    else if (drop_evt && (rx_drop_count != '1)) rx_drop_count <= rx_drop_count + CNT_W'(1);
  end

  gbe_rx_dpram #(
    .AW(BANK_AWIDTH + 1),
    .DW(32)
  ) u_ram (
    .clk     (wb_clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr ({~fill_bank, cpu_rx_buffer_addr}),
    .rd_data (cpu_rx_buffer_rd_data)
  );

endmodule

// File: tb/tb_gbe_cpu_rx_buffer.sv
// Directed bench for gbe_cpu_rx_buffer with hand-computed expectations.
module tb_gbe_cpu_rx_buffer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_eof = 1'b0;
  logic        rx_bad = 1'b0;
  logic [8:0]  cpu_rx_buffer_addr = 9'd0;
  logic [31:0] cpu_rx_buffer_rd_data;
  logic [11:0] cpu_rx_size;
  logic        cpu_rx_ready;
  logic        cpu_rx_ack = 1'b0;
  logic [15:0] rx_frame_count;
  logic [15:0] rx_drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  gbe_cpu_rx_buffer #(.BANK_AWIDTH(9)) dut (
    .wb_clk_i              (wb_clk_i),
    .wb_rst_n_i            (wb_rst_n_i),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .rx_eof                (rx_eof),
    .rx_bad                (rx_bad),
    .cpu_rx_buffer_addr    (cpu_rx_buffer_addr),
    .cpu_rx_buffer_rd_data (cpu_rx_buffer_rd_data),
    .cpu_rx_size           (cpu_rx_size),
    .cpu_rx_ready          (cpu_rx_ready),
    .cpu_rx_ack            (cpu_rx_ack),
    .rx_frame_count        (rx_frame_count),
    .rx_drop_count         (rx_drop_count)
  );

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Bytes are first, first+step, ...; returns just after the eof byte's edge.
  task automatic send_frame(input logic [7:0] first, input logic [7:0] step,
                            input int len, input logic bad);
    logic [7:0] d;
    d = first;
    for (int i = 0; i < len; i++) begin
      rx_data  = d;
      rx_valid = 1'b1;
      rx_eof   = (i == len - 1);
      rx_bad   = bad && (i == len - 1);
      tick();
      d = d + step;
    end
    rx_valid = 1'b0;
    rx_eof   = 1'b0;
    rx_bad   = 1'b0;
  endtask

  task automatic read_word(input logic [8:0] a, output logic [31:0] w);
    cpu_rx_buffer_addr = a;
    tick();
    w = cpu_rx_buffer_rd_data;
  endtask

  task automatic wait_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (cpu_rx_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    wb_rst_n_i = 1'b0;
    cpu_rx_ack = 1'b0;
    tick();
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd0) begin n_fail++; $display("FAIL reset_size: got %0d expected 0", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d expected 0", rx_frame_count); end
    n_checks++; if (rx_drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drops: got %0d expected 0", rx_drop_count); end
    wb_rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    logic [31:0] w;
    cpu_rx_ack = 1'b1;
    send_frame(8'h00, 8'h01, 64, 1'b0);
    n_checks++; if (cpu_rx_ready !== 1'b0) begin n_fail++; $display("FAIL good64_eof1: got %b expected 0", cpu_rx_ready); end
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL good64_eof2_ready: got %b expected 1", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd63) begin n_fail++; $display("FAIL good64_size: got %0d expected 63", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd1) begin n_fail++; $display("FAIL good64_frames: got %0d expected 1", rx_frame_count); end
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b0) begin n_fail++; $display("FAIL good64_ready_drop: got %b expected 0", cpu_rx_ready); end
    read_word(9'd0, w);
    n_checks++; if (w !== 32'h00010203) begin n_fail++; $display("FAIL good64_word0: got %h expected 00010203", w); end
    read_word(9'd15, w);
    n_checks++; if (w !== 32'h3C3D3E3F) begin n_fail++; $display("FAIL good64_word15: got %h expected 3c3d3e3f", w); end
  endtask

  task automatic test_short_frame();
    logic [31:0] w;
    send_frame(8'hAA, 8'h11, 5, 1'b0);
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL short5_ready: got %b expected 1", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd4) begin n_fail++; $display("FAIL short5_size: got %0d expected 4", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd2) begin n_fail++; $display("FAIL short5_frames: got %0d expected 2", rx_frame_count); end
    read_word(9'd0, w);
    n_checks++; if (w !== 32'hAABBCCDD) begin n_fail++; $display("FAIL short5_word0: got %h expected aabbccdd", w); end
    read_word(9'd1, w);
    n_checks++; if (w !== 32'hEE000000) begin n_fail++; $display("FAIL short5_word1: got %h expected ee000000", w); end
  endtask

  task automatic test_bad_frame();
    logic [31:0] w;
    bit seen;
    send_frame(8'h00, 8'h01, 8, 1'b1);
    n_checks++; if (rx_drop_count !== 16'd1) begin n_fail++; $display("FAIL bad_drops: got %0d expected 1", rx_drop_count); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_rx_ready) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bad_no_ready: got %b expected 0", seen); end
    n_checks++; if (rx_frame_count !== 16'd2) begin n_fail++; $display("FAIL bad_frames: got %0d expected 2", rx_frame_count); end
    send_frame(8'h11, 8'h11, 3, 1'b0);
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL after_bad_ready: got %b expected 1", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd2) begin n_fail++; $display("FAIL after_bad_size: got %0d expected 2", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd3) begin n_fail++; $display("FAIL after_bad_frames: got %0d expected 3", rx_frame_count); end
    read_word(9'd0, w);
    n_checks++; if (w !== 32'h11223300) begin n_fail++; $display("FAIL after_bad_word0: got %h expected 11223300", w); end
  endtask

  task automatic test_oversize();
    logic [31:0] w;
    bit seen;
    send_frame(8'h00, 8'h01, 2049, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_rx_ready) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL over_no_ready: got %b expected 0", seen); end
    n_checks++; if (rx_drop_count !== 16'd2) begin n_fail++; $display("FAIL over_drops: got %0d expected 2", rx_drop_count); end
    send_frame(8'h00, 8'h01, 2048, 1'b0);
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL max_ready: got %b expected 1", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd2047) begin n_fail++; $display("FAIL max_size: got %0d expected 2047", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd4) begin n_fail++; $display("FAIL max_frames: got %0d expected 4", rx_frame_count); end
    read_word(9'd511, w);
    n_checks++; if (w !== 32'hFCFDFEFF) begin n_fail++; $display("FAIL max_word511: got %h expected fcfdfeff", w); end
    read_word(9'd0, w);
    n_checks++; if (w !== 32'h00010203) begin n_fail++; $display("FAIL max_word0: got %h expected 00010203", w); end
  endtask

  task automatic test_busy();
    logic [31:0] w;
    bit ok;
    send_frame(8'h50, 8'h01, 2, 1'b0);
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL busy_p_ready: got %b expected 1", cpu_rx_ready); end
    tick();
    cpu_rx_ack = 1'b0;
    send_frame(8'h01, 8'h01, 4, 1'b0);
    repeat (3) tick();
    n_checks++; if (cpu_rx_ready !== 1'b0) begin n_fail++; $display("FAIL busy_a_waits: got %b expected 0", cpu_rx_ready); end
    send_frame(8'hB1, 8'h01, 3, 1'b0);
    tick();
    n_checks++; if (rx_drop_count !== 16'd3) begin n_fail++; $display("FAIL busy_b_dropped: got %0d expected 3", rx_drop_count); end
    n_checks++; if (cpu_rx_size !== 12'd1) begin n_fail++; $display("FAIL busy_size_stable: got %0d expected 1", cpu_rx_size); end
    read_word(9'd0, w);
    n_checks++; if (w !== 32'h50510000) begin n_fail++; $display("FAIL busy_bank_stable: got %h expected 50510000", w); end
    cpu_rx_ack = 1'b1;
    wait_ready(10, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_a_offered: got %b expected 1 (timeout)", ok); end
    n_checks++; if (cpu_rx_size !== 12'd3) begin n_fail++; $display("FAIL busy_a_size: got %0d expected 3", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd6) begin n_fail++; $display("FAIL busy_frames: got %0d expected 6", rx_frame_count); end
    read_word(9'd0, w);
    n_checks++; if (w !== 32'h01020304) begin n_fail++; $display("FAIL busy_a_word0: got %h expected 01020304", w); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    send_frame(8'h10, 8'h01, 4, 1'b0);
    send_frame(8'h20, 8'h01, 4, 1'b0);
    n_checks++; if (cpu_rx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_eof1: got %b expected 0", cpu_rx_ready); end
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd3) begin n_fail++; $display("FAIL b2b_size: got %0d expected 3", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd8) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 8", rx_frame_count); end
    read_word(9'd0, w);
    n_checks++; if (w !== 32'h20212223) begin n_fail++; $display("FAIL b2b_word0: got %h expected 20212223", w); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    for (int i = 0; i < 10; i++) begin
      rx_data  = 8'(8'h70 + i);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid   = 1'b0;
    wb_rst_n_i = 1'b0;
    tick();
    wb_rst_n_i = 1'b1;
    n_checks++; if (rx_frame_count !== 16'd0) begin n_fail++; $display("FAIL midfill_frames: got %0d expected 0", rx_frame_count); end
    n_checks++; if (rx_drop_count !== 16'd0) begin n_fail++; $display("FAIL midfill_drops: got %0d expected 0", rx_drop_count); end
    n_checks++; if (cpu_rx_size !== 12'd0) begin n_fail++; $display("FAIL midfill_size: got %0d expected 0", cpu_rx_size); end
    cpu_rx_ack = 1'b0;
    send_frame(8'h30, 8'h01, 4, 1'b0);
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b0) begin n_fail++; $display("FAIL offer_wait: got %b expected 0", cpu_rx_ready); end
    cpu_rx_ack = 1'b1;
    tick();
    cpu_rx_ack = 1'b0;
    tick();
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL offer_held: got %b expected 1", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd3) begin n_fail++; $display("FAIL offer_size: got %0d expected 3", cpu_rx_size); end
    wb_rst_n_i = 1'b0;
    tick();
    wb_rst_n_i = 1'b1;
    n_checks++; if (cpu_rx_ready !== 1'b0) begin n_fail++; $display("FAIL offer_rst_ready: got %b expected 0", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd0) begin n_fail++; $display("FAIL offer_rst_size: got %0d expected 0", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd0) begin n_fail++; $display("FAIL offer_rst_frames: got %0d expected 0", rx_frame_count); end
    cpu_rx_ack = 1'b1;
    send_frame(8'h60, 8'h01, 6, 1'b0);
    tick();
    n_checks++; if (cpu_rx_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", cpu_rx_ready); end
    n_checks++; if (cpu_rx_size !== 12'd5) begin n_fail++; $display("FAIL post_rst_size: got %0d expected 5", cpu_rx_size); end
    n_checks++; if (rx_frame_count !== 16'd1) begin n_fail++; $display("FAIL post_rst_frames: got %0d expected 1", rx_frame_count); end
    n_checks++; if (rx_drop_count !== 16'd0) begin n_fail++; $display("FAIL post_rst_drops: got %0d expected 0", rx_drop_count); end
    read_word(9'd1, w);
    n_checks++; if (w !== 32'h64650000) begin n_fail++; $display("FAIL post_rst_word1: got %h expected 64650000", w); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_bad_frame();
    test_oversize();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
